// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register (request -> grant -> capture -> done).
// Optional locked back-to-back bursts are enabled by defining SRA_LOCK_EN.
module shared_reg_arbiter #(
  parameter int              NREQ     = 4,
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              MAX_LOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;

  // ptr doubles as the index of the current grant holder while a write is in flight.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef SRA_LOCK_EN
  logic [3:0] lock_cnt;
  logic       lock_hold;

  assign lock_hold = req[ptr] && lock[ptr] && (lock_cnt < 4'(MAX_LOCK - 1));
`else
  logic       unused_lock;
  logic [3:0] unused_max_lock;

  assign unused_lock     = ^lock;
  assign unused_max_lock = 4'(MAX_LOCK);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      q     <= RST_VAL;
      ptr   <= PW'(NREQ - 1);
`ifdef SRA_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (found) begin
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            ptr   <= win;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // Capture regardless of req: the requester promised stable data until done.
          q     <= wdata[ptr*WIDTH +: WIDTH];
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
`ifdef SRA_LOCK_EN
          if (lock_hold) begin
            lock_cnt <= lock_cnt + 4'd1;
            state    <= GRANT;
          end else begin
            lock_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: begin
          gnt   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: each expected write (grant, q) is queued when
// stimulus is driven and compared when done pulses. Also follows SRA_LOCK_EN if defined.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  shared_reg_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .RST_VAL(8'hA5), .MAX_LOCK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .done(done), .busy(busy), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 20);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Scoreboard: every done pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      $display("write gnt=%b q=%h", gnt, q);
      if (exp_q.size() == 0) begin
        check("sb_extra_done", 32'(done), 32'd0);
      end else begin
        check("sb_write", {20'd0, gnt, q}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    step(); step(); step();

    // 1: idle after reset
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_q", 32'(q), 32'hA5);
      check("rst_flags", {26'd0, gnt, busy, done}, 32'd0);
    end

    // 2: single request, cycle-exact latency
    wdata[2*8 +: 8] = 8'h3C;
    req = 4'b0100;
    exp_q.push_back({4'b0100, 8'h3C});
    step();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_done_early", 32'(done), 32'd0);
    step();
    check("t2_done", 32'(done), 32'd1);
    check("t2_q", 32'(q), 32'h3C);
    req = '0;
    step();
    check("t2_idle", {26'd0, gnt, busy, done}, 32'd0);

    // 3: all requesting, strict rotation from reset pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) wdata[i*8 +: 8] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back({4'(1 << (i % 4)), 8'(8'h10 + (i % 4))});
    for (int i = 0; i < 5; i++) begin
      wait_done("t3", n);
      check("t3_spacing", 32'(n), (i == 0) ? 32'd2 : 32'd3);
    end
    req = '0;
    step();

    // 4: requester 3 joins while 0 finishes; pointer moves past 0
    wdata[0 +: 8]   = 8'h5A;
    wdata[3*8 +: 8] = 8'hC3;
    req = 4'b0001;
    exp_q.push_back({4'b0001, 8'h5A});
    exp_q.push_back({4'b1000, 8'hC3});
    wait_done("t4a", n);
    req = 4'b1001;
    step();
    step();
    check("t4_gnt", 32'(gnt), 32'h8);
    wait_done("t4b", n);
    req = '0;
    step();

    // 5: reset during GRANT aborts the capture
    wdata[1*8 +: 8] = 8'hFF;
    req = 4'b0010;
    step();
    check("t5_gnt_pre", 32'(gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt_rst", 32'(gnt), 32'd0);
    check("t5_q_rst", 32'(q), 32'hA5);
    check("t5_busy_rst", 32'(busy), 32'd0);
    step();
    check("t5_q_held", 32'(q), 32'hA5);
    rst_n = 1'b1;
    wdata[0 +: 8] = 8'h77;
    req = 4'b0011;
    exp_q.push_back({4'b0001, 8'h77});
    step();
    check("t5_gnt_post", 32'(gnt), 32'h1);
    wait_done("t5", n);
    req = '0;
    step();

    // 6: lock request from requester 0 competing with 1
    do_reset();
    wdata[0 +: 8]   = 8'h21;
    wdata[1*8 +: 8] = 8'h43;
    lock = 4'b0001;
    req  = 4'b0011;
`ifdef SRA_LOCK_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0001, 8'h21});
    exp_q.push_back({4'b0010, 8'h43});
    for (int i = 0; i < 5; i++) begin
      wait_done("t6", n);
      check("t6_spacing", 32'(n), (i == 0) ? 32'd2 : ((i < 4) ? 32'd2 : 32'd3));
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? {4'b0001, 8'h21} : {4'b0010, 8'h43});
    for (int i = 0; i < 4; i++) begin
      wait_done("t6", n);
      check("t6_spacing", 32'(n), (i == 0) ? 32'd2 : 32'd3);
    end
`endif
    req  = '0;
    lock = '0;
    step();
    step();
    check("t6_idle", {26'd0, gnt, busy, done}, 32'd0);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
